// File: rtl/count_wrap_monitor.sv
// Monitors an upstream 4-bit up counter: counts wraps, flags broken sequences and raises a threshold irq.
// Optional macro CWM_WRAP_SATURATE_EN makes wrap_cnt saturate at all-ones instead of rolling over.
module count_wrap_monitor #(
    parameter int WRAP_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        count_in,
    input  logic              count_vld,
    input  logic [3:0]        thresh,
    input  logic              thresh_load,
    input  logic              arm,
    input  logic              irq_ack,
    output logic              irq,
    output logic              wrap_pulse,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic              seq_err,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ARMED = 2'b01,
        FIRED = 2'b10
    } state_t;

    state_t     cur, nxt;
    logic [3:0] prev;
    logic [3:0] thr;
    logic       prev_ok;
    logic       hit;
    logic       wrap;
    logic       brk;

    // Only samples following an initialised prev can hit, wrap or break the sequence.
    always_comb begin
        hit  = count_vld && prev_ok && (count_in == thr);
        wrap = count_vld && prev_ok && (prev == 4'hF) && (count_in == 4'h0);
        brk  = count_vld && prev_ok && (count_in != prev) && (count_in != prev + 4'd1);
    end

    always_comb begin
        nxt = cur;
        case (cur)
            IDLE:    if (arm)     nxt = ARMED;
            ARMED:   if (hit)     nxt = FIRED;
            FIRED:   if (irq_ack) nxt = IDLE;
            default:              nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur        <= IDLE;
            irq        <= 1'b0;
            wrap_pulse <= 1'b0;
            wrap_cnt   <= '0;
            seq_err    <= 1'b0;
            prev       <= 4'h0;
            prev_ok    <= 1'b0;
            thr        <= 4'hF;
        end else begin
            cur        <= nxt;
            irq        <= (nxt == FIRED);
            wrap_pulse <= wrap;
`ifdef CWM_WRAP_SATURATE_EN
            if (wrap && (wrap_cnt != '1)) wrap_cnt <= wrap_cnt + WRAP_W'(1);
`else
            if (wrap) wrap_cnt <= wrap_cnt + WRAP_W'(1);
`endif
            if (brk) seq_err <= 1'b1;
            if (count_vld) begin
                prev    <= count_in;
                prev_ok <= 1'b1;
            end
            if (thresh_load) thr <= thresh;
        end
    end

    assign state = cur;

endmodule

// File: tb/tb_count_wrap_monitor.sv
// Randomised and directed self-checking bench for count_wrap_monitor (two widths driven in parallel).
module tb_count_wrap_monitor;

    logic       clk = 1'b0;
    logic       reset, count_vld, thresh_load, arm, irq_ack;
    logic [3:0] count_in, thresh;

    logic       irq8, pulse8, err8;
    logic [7:0] cnt8;
    logic [1:0] st8;
    logic       irq2, pulse2, err2;
    logic [1:0] cnt2;
    logic [1:0] st2;

    int checks = 0;
    int errors = 0;

    // Reference model: abstract behaviour of the monitor.
    int last;       // last valid sample, -1 when none since reset
    int thr_m;
    int wraps;      // unbounded wrap total
    bit err_m;
    bit pulse_m;
    int mode;       // 0 idle, 1 armed, 2 fired

    always #5 clk = ~clk;

    count_wrap_monitor dut8 (
        .clk(clk), .reset(reset), .count_in(count_in), .count_vld(count_vld),
        .thresh(thresh), .thresh_load(thresh_load), .arm(arm), .irq_ack(irq_ack),
        .irq(irq8), .wrap_pulse(pulse8), .wrap_cnt(cnt8), .seq_err(err8), .state(st8)
    );

    count_wrap_monitor #(.WRAP_W(2)) dut2 (
        .clk(clk), .reset(reset), .count_in(count_in), .count_vld(count_vld),
        .thresh(thresh), .thresh_load(thresh_load), .arm(arm), .irq_ack(irq_ack),
        .irq(irq2), .wrap_pulse(pulse2), .wrap_cnt(cnt2), .seq_err(err2), .state(st2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_cnt(input int total, input int w);
        int top = (1 << w) - 1;
`ifdef CWM_WRAP_SATURATE_EN
        return (total > top) ? top : total;
`else
        return total % (top + 1);
`endif
    endfunction

    function automatic void model_step();
        bit hit;
        hit = 1'b0;
        if (reset) begin
            last = -1; thr_m = 15; wraps = 0; err_m = 0; pulse_m = 0; mode = 0;
            return;
        end
        pulse_m = 0;
        if (count_vld) begin
            if (last >= 0) begin
                if (last == 15 && count_in == 0) begin
                    wraps++;
                    pulse_m = 1;
                end
                if (int'(count_in) != last && int'(count_in) != (last + 1) % 16) err_m = 1;
                hit = (int'(count_in) == thr_m);
            end
            last = count_in;
        end
        case (mode)
            0: if (arm) mode = 1;
            1: if (hit) mode = 2;
            default: if (irq_ack) mode = 0;
        endcase
        if (thresh_load) thr_m = thresh;
    endfunction

    task automatic check_all();
        check("irq8",   32'(irq8),   32'(mode == 2));
        check("pulse8", 32'(pulse8), 32'(pulse_m));
        check("cnt8",   32'(cnt8),   exp_cnt(wraps, 8));
        check("err8",   32'(err8),   32'(err_m));
        check("st8",    32'(st8),    mode);
        check("irq2",   32'(irq2),   32'(mode == 2));
        check("pulse2", 32'(pulse2), 32'(pulse_m));
        check("cnt2",   32'(cnt2),   exp_cnt(wraps, 2));
        check("err2",   32'(err2),   32'(err_m));
        check("st2",    32'(st2),    mode);
    endtask

    // Apply one cycle of inputs, advance the model at the edge, compare just after it.
    task automatic cyc(input bit rst, input bit vld, input int cin, input bit tl,
                       input int th, input bit a, input bit ack);
        reset = rst; count_vld = vld; count_in = 4'(cin);
        thresh_load = tl; thresh = 4'(th); arm = a; irq_ack = ack;
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic sample(input int cin);
        cyc(0, 1, cin, 0, 0, 0, 0);
    endtask

    initial begin
        int c;
        reset = 1; count_vld = 0; count_in = 0; thresh_load = 0; thresh = 0; arm = 0; irq_ack = 0;
        last = -1; thr_m = 15; wraps = 0; err_m = 0; pulse_m = 0; mode = 0;

        // Reset state, then a full 0..F,0 sweep gives exactly one wrap.
        cyc(1, 0, 0, 0, 0, 0, 0);
        check("rst_cnt", 32'(cnt8), 0);
        for (int i = 0; i < 16; i++) sample(i);
        sample(0);
        check("wrap_pulse", 32'(pulse8), 1);
        check("wrap_cnt1", 32'(cnt8), 1);
        sample(1);
        check("pulse_once", 32'(pulse8), 0);

        // Threshold load, arm, hit, ack.
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 5, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0);
        sample(3); sample(4); sample(5);
        check("fired_st", 32'(st8), 2);
        check("fired_irq", 32'(irq8), 1);
        cyc(0, 0, 0, 0, 0, 1, 0);
        check("arm_ign", 32'(st8), 2);
        cyc(0, 0, 0, 0, 0, 0, 1);
        check("ack_irq", 32'(irq8), 0);

        // Sequence break is sticky until reset.
        sample(6); sample(2); sample(3); sample(7);
        check("seq_err", 32'(err8), 1);
        c = 7;
        for (int i = 0; i < 20; i++) begin c = (c + 1) % 16; sample(c); end
        check("seq_sticky", 32'(err8), 1);
        cyc(1, 0, 0, 0, 0, 0, 0);
        check("seq_clr", 32'(err8), 0);

        // Ack beats a simultaneous match; repeated sample is legal.
        cyc(0, 0, 0, 1, 7, 1, 0);
        sample(6); sample(7);
        cyc(0, 1, 7, 0, 0, 0, 1);
        check("ack_wins", 32'(st8), 0);
        check("repeat_ok", 32'(err8), 0);

        // Arm with a simultaneous match only arms.
        cyc(0, 1, 7, 0, 0, 1, 0);
        check("arm_only", 32'(st8), 1);

        // Five wraps on both widths, then reset while armed.
        cyc(1, 0, 0, 0, 0, 0, 0);
        sample(15);
        for (int w = 0; w < 5; w++) begin sample(0); sample(15); end
`ifdef CWM_WRAP_SATURATE_EN
        check("w2_five", 32'(cnt2), 3);
`else
        check("w2_five", 32'(cnt2), 1);
`endif
        cyc(0, 0, 0, 0, 0, 1, 0);
        cyc(1, 1, 15, 0, 0, 0, 0);
        check("rst_armed", 32'(st8), 0);

        // Randomised traffic, mostly in-sequence samples.
        c = 0;
        for (int i = 0; i < 3000; i++) begin
            int r;
            bit vld;
            r = int'($urandom_range(0, 99));
            vld = ($urandom_range(0, 3) != 0);
            if (r < 70)      c = (c + 1) % 16;
            else if (r < 85) c = c;
            else             c = int'($urandom_range(0, 15));
            cyc(($urandom_range(0, 299) == 0), vld, c,
                ($urandom_range(0, 19) == 0), int'($urandom_range(0, 15)),
                ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/count_wrap_monitor.md
COUNT_WRAP_MONITOR -- requirements
Module: count_wrap_monitor

Interface
REQ-001 The block SHALL have parameter WRAP_W, default 8, giving the width of the wrap counter.
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 count_in  input  4  sample from the upstream 4-bit up counter.
REQ-005 count_vld  input  1  count_in is valid this cycle.
REQ-006 thresh  input  4  threshold value, captured only when thresh_load=1.
REQ-007 thresh_load  input  1  load thresh into the internal threshold register.
REQ-008 arm  input  1  request to arm the threshold detector.
REQ-009 irq_ack  input  1  clears a pending irq.
REQ-010 irq  output  1  level, registered; threshold hit pending.
REQ-011 wrap_pulse  output  1  one-cycle registered pulse per detected wrap.
REQ-012 wrap_cnt  output  WRAP_W  number of wraps detected since reset.
REQ-013 seq_err  output  1  sticky flag: the counter sequence was broken.
REQ-014 state  output  2  FSM state (IDLE=2'b00, ARMED=2'b01, FIRED=2'b10).

Function
REQ-015 The block SHALL hold a 4-bit previous-sample register prev and a flag prev_ok that are updated only on cycles with count_vld=1; both hold their value across cycles with count_vld=0.
REQ-016 A wrap SHALL be a valid sample with count_in=4'h0 while prev_ok=1 and prev=4'hF; wrap_pulse SHALL be 1 on the cycle after that sample and 0 otherwise.
REQ-017 Each wrap SHALL increment wrap_cnt by 1 in the same edge that sets wrap_pulse; behaviour at the all-ones value is set by REQ-031/032.
REQ-018 seq_err SHALL be set in the cycle after any valid sample with prev_ok=1 whose count_in is neither prev nor (prev+1) mod 16; it SHALL then stay set until reset.
REQ-019 The first valid sample after reset SHALL only initialise prev and set prev_ok; it SHALL NOT cause a wrap, seq_err or a hit.
REQ-020 A thresh_load pulse SHALL update the threshold register at that edge; the new value SHALL apply to samples from the next cycle onward.
REQ-021 IDLE: arm=1 -> ARMED. Any other input -> stay in IDLE.
REQ-022 ARMED: a valid sample equal to the threshold register -> FIRED, and irq=1 from the next cycle (one-cycle latency).
REQ-023 FIRED: irq stays 1; irq_ack=1 -> IDLE, and irq=0 from the next cycle.
REQ-024 arm is ignored in ARMED and FIRED; irq_ack is ignored in IDLE and ARMED.
REQ-025 When irq_ack and a matching sample arrive in the same cycle in FIRED, the ack SHALL win: the next state is IDLE and no new hit is recorded.
REQ-026 An arm pulse and a matching sample in the same cycle in IDLE SHALL go to ARMED only; the match is not counted.
REQ-027 Wrap detection and seq_err SHALL operate in every FSM state.

Reset
REQ-028 On reset=1 at a clock edge, the block SHALL set state=IDLE, irq=0, wrap_pulse=0, wrap_cnt=0, seq_err=0, prev=4'h0, prev_ok=0 and threshold=4'hF.
REQ-029 Reset SHALL take priority over every other input, including mid-operation in ARMED or FIRED.
REQ-030 All outputs SHALL be driven directly from registers; there SHALL be no combinational path from any input to any output.

Configuration
REQ-031 With macro CWM_WRAP_SATURATE_EN defined, wrap_cnt SHALL saturate at all-ones; wrap_pulse still fires on each wrap.
REQ-032 Without CWM_WRAP_SATURATE_EN, wrap_cnt SHALL roll over from all-ones to 0.

Verification
REQ-033 Reset, then count_vld=1 with count_in stepping 0..F,0 -> exactly one wrap_pulse, one cycle after the 0 sample; wrap_cnt=1; seq_err=0.
REQ-034 thresh=4'h5 with thresh_load=1, then arm, then samples 3,4,5 -> state FIRED and irq=1 one cycle after the 5 sample; irq_ack -> IDLE and irq=0 on the next cycle.
REQ-035 Samples 2,3,7 -> seq_err=1 one cycle after the 7 sample, and it stays 1 after 20 further correct samples; reset -> seq_err=0.
REQ-036 In FIRED, irq_ack=1 together with a matching sample -> next state IDLE, irq=0; a repeated sample (7,7) sets no seq_err.
REQ-037 WRAP_W=2, 5 wraps -> wrap_cnt=3 with CWM_WRAP_SATURATE_EN defined and wrap_cnt=1 without it; reset asserted while ARMED -> IDLE and all outputs at reset values on the next cycle.
